// File: rtl/freecell_pkg.sv
// -----------------------------------------------------------------------------
// freecell_pkg
// Shared definitions for the FreeCell move controller:
//   - location encoding: 0xxx tableau, 10xx free cell, 11xx home
//   - card encoding: {suit[1:0], rank[3:0]}, rank 1..13
//   - FSM state enum for freecell_move_ctrl
//   - small decode helpers for locations and cards
// -----------------------------------------------------------------------------
package freecell_pkg;

  localparam int CARD_W = 6;
  localparam int LOC_W  = 4;

  // Location prefixes (upper bits of a 4-bit location).
  localparam logic [0:0] LOC_TAB  = 1'b0;
  localparam logic [1:0] LOC_FREE = 2'b10;
  localparam logic [1:0] LOC_HOME = 2'b11;

  localparam logic [3:0] RANK_ACE     = 4'd1;
  localparam logic [9:0] MOVE_CNT_MAX = 10'd1023;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_SRC = 3'd1,
    RD_DST = 3'd2,
    CHECK  = 3'd3,
    POP    = 3'd4,
    PUSH   = 3'd5,
    RESP   = 3'd6
  } state_t;

  function automatic logic loc_is_tab(input logic [LOC_W-1:0] loc);
    return (loc[3] == LOC_TAB);
  endfunction

  function automatic logic loc_is_free(input logic [LOC_W-1:0] loc);
    return (loc[3:2] == LOC_FREE);
  endfunction

  function automatic logic loc_is_home(input logic [LOC_W-1:0] loc);
    return (loc[3:2] == LOC_HOME);
  endfunction

  function automatic logic [3:0] card_rank(input logic [CARD_W-1:0] card);
    return card[3:0];
  endfunction

  function automatic logic [1:0] card_suit(input logic [CARD_W-1:0] card);
    return card[5:4];
  endfunction

  // Suits 1 and 3 are red, 0 and 2 are black.
  function automatic logic card_red(input logic [CARD_W-1:0] card);
    return card[4];
  endfunction

endpackage

// File: rtl/freecell_logic.sv
// -----------------------------------------------------------------------------
// freecell_logic
// Combinational legality check for a single-card FreeCell move.
// Ports:
//   src_loc_i, dst_loc_i   source / destination location
//   src_card_i, src_empty_i top card of source and its emptiness
//   dst_card_i, dst_empty_i, dst_full_i  destination top card and status
//   legal_o                 1 when the move is legal
// Rules:
//   illegal if src==dst, source is a home cell, source empty or dest full;
//   tableau dest: empty, or top card one rank higher and opposite colour;
//   free cell dest: must be empty;
//   home dest: empty needs an ace, otherwise same suit and one rank higher.
// -----------------------------------------------------------------------------
module freecell_logic
  import freecell_pkg::*;
(
  input  logic [LOC_W-1:0]  src_loc_i,
  input  logic [LOC_W-1:0]  dst_loc_i,
  input  logic [CARD_W-1:0] src_card_i,
  input  logic              src_empty_i,
  input  logic [CARD_W-1:0] dst_card_i,
  input  logic              dst_empty_i,
  input  logic              dst_full_i,
  output logic              legal_o
);

  logic [4:0] src_rank_s;
  logic [4:0] dst_rank_s;

  // Legality decision from the registered move snapshot.
  always_comb begin
    legal_o    = 1'b0;
    // Ranks widened so rank+1 can never wrap onto a valid rank.
    src_rank_s = {1'b0, card_rank(src_card_i)};
    dst_rank_s = {1'b0, card_rank(dst_card_i)};
    if ((src_loc_i == dst_loc_i) || loc_is_home(src_loc_i) || src_empty_i || dst_full_i) begin
      legal_o = 1'b0;
    end else if (loc_is_tab(dst_loc_i)) begin
      legal_o = dst_empty_i ||
                ((dst_rank_s == (src_rank_s + 5'd1)) &&
                 (card_red(dst_card_i) != card_red(src_card_i)));
    end else if (loc_is_free(dst_loc_i)) begin
      legal_o = dst_empty_i;
    end else begin
      if (dst_empty_i) begin
        legal_o = (card_rank(src_card_i) == RANK_ACE);
      end else begin
        legal_o = (card_suit(dst_card_i) == card_suit(src_card_i)) &&
                  (src_rank_s == (dst_rank_s + 5'd1));
      end
    end
  end

endmodule

// File: rtl/freecell_move_ctrl.sv
// -----------------------------------------------------------------------------
// freecell_move_ctrl
// Executes one FreeCell card move per request: reads source and destination
// through a combinational board read port, checks legality, then pops the
// source and pushes the card onto the destination, and reports the outcome.
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_src, req_dst               move locations
//   rd_loc -> rd_card/rd_empty/rd_full   same-cycle board read
//   pop_en/pop_loc, push_en/push_loc/push_card   board write strobes
//   rsp_valid, rsp_ok              one-cycle completion pulse and result
//   move_count                     legal moves performed (FREECELL_MOVE_CNT_EN)
// Configuration macro: FREECELL_MOVE_CNT_EN adds the saturating move counter.
// Latency from accept edge to the edge sampling rsp_valid: 6 legal, 4 illegal.
// -----------------------------------------------------------------------------
module freecell_move_ctrl
  import freecell_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LOC_W-1:0]  req_src,
  input  logic [LOC_W-1:0]  req_dst,
  output logic [LOC_W-1:0]  rd_loc,
  input  logic [CARD_W-1:0] rd_card,
  input  logic              rd_empty,
  input  logic              rd_full,
  output logic              pop_en,
  output logic [LOC_W-1:0]  pop_loc,
  output logic              push_en,
  output logic [LOC_W-1:0]  push_loc,
  output logic [CARD_W-1:0] push_card,
  output logic              rsp_valid,
  output logic              rsp_ok
`ifdef FREECELL_MOVE_CNT_EN
  ,
  output logic [9:0]        move_count
`endif
);

  state_t            state_q, state_d;
  logic [LOC_W-1:0]  src_q, src_d;
  logic [LOC_W-1:0]  dst_q, dst_d;
  logic [CARD_W-1:0] src_card_q, src_card_d;
  logic [CARD_W-1:0] dst_card_q, dst_card_d;
  logic              src_empty_q, src_empty_d;
  logic              dst_empty_q, dst_empty_d;
  logic              dst_full_q, dst_full_d;
  logic              ok_q, ok_d;
  logic              legal_s;

  // Legality only ever sees the registered snapshot, never the live read port.
  freecell_logic u_logic (
    .src_loc_i   (src_q),
    .dst_loc_i   (dst_q),
    .src_card_i  (src_card_q),
    .src_empty_i (src_empty_q),
    .dst_card_i  (dst_card_q),
    .dst_empty_i (dst_empty_q),
    .dst_full_i  (dst_full_q),
    .legal_o     (legal_s)
  );

  // State and move snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= {LOC_W{1'b0}};
      dst_q       <= {LOC_W{1'b0}};
      src_card_q  <= {CARD_W{1'b0}};
      dst_card_q  <= {CARD_W{1'b0}};
      src_empty_q <= 1'b0;
      dst_empty_q <= 1'b0;
      dst_full_q  <= 1'b0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      src_card_q  <= src_card_d;
      dst_card_q  <= dst_card_d;
      src_empty_q <= src_empty_d;
      dst_empty_q <= dst_empty_d;
      dst_full_q  <= dst_full_d;
      ok_q        <= ok_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    src_card_d  = src_card_q;
    dst_card_d  = dst_card_q;
    src_empty_d = src_empty_q;
    dst_empty_d = dst_empty_q;
    dst_full_d  = dst_full_q;
    ok_d        = ok_q;
    req_ready   = 1'b0;
    rd_loc      = {LOC_W{1'b0}};
    pop_en      = 1'b0;
    pop_loc     = {LOC_W{1'b0}};
    push_en     = 1'b0;
    push_loc    = {LOC_W{1'b0}};
    push_card   = {CARD_W{1'b0}};
    rsp_valid   = 1'b0;
    rsp_ok      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          src_d   = req_src;
          dst_d   = req_dst;
          state_d = RD_SRC;
        end else begin
          state_d = IDLE;
        end
      end
      RD_SRC: begin
        rd_loc      = src_q;
        src_card_d  = rd_card;
        src_empty_d = rd_empty;
        state_d     = RD_DST;
      end
      RD_DST: begin
        rd_loc      = dst_q;
        dst_card_d  = rd_card;
        dst_empty_d = rd_empty;
        dst_full_d  = rd_full;
        state_d     = CHECK;
      end
      CHECK: begin
        ok_d = legal_s;
        if (legal_s) begin
          state_d = POP;
        end else begin
          state_d = RESP;
        end
      end
      POP: begin
        pop_en  = 1'b1;
        pop_loc = src_q;
        state_d = PUSH;
      end
      PUSH: begin
        push_en   = 1'b1;
        push_loc  = dst_q;
        push_card = src_card_q;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_ok    = ok_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef FREECELL_MOVE_CNT_EN
  logic [9:0] cnt_q, cnt_d;

  // Saturating count of performed moves, bumped as the push strobe fires.
  always_comb begin
    if ((state_q == PUSH) && (cnt_q != MOVE_CNT_MAX)) begin
      cnt_d = cnt_q + 10'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Move counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 10'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign move_count = cnt_q;
`endif

endmodule

// File: tb/tb_freecell_move_ctrl.sv
module tb_freecell_move_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_src, req_dst;
  logic [3:0] rd_loc;
  logic [5:0] rd_card;
  logic       rd_empty, rd_full;
  logic       pop_en;
  logic [3:0] pop_loc;
  logic       push_en;
  logic [3:0] push_loc;
  logic [5:0] push_card;
  logic       rsp_valid, rsp_ok;
`ifdef FREECELL_MOVE_CNT_EN
  logic [9:0] move_count;
`endif

  // Board model: top card and status of every location.
  logic [5:0] b_card [16];
  logic       b_empty[16];
  logic       b_full [16];

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  assign rd_card  = b_card[rd_loc];
  assign rd_empty = b_empty[rd_loc];
  assign rd_full  = b_full[rd_loc];

  always #5 clk = ~clk;

  freecell_move_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .rd_loc(rd_loc), .rd_card(rd_card), .rd_empty(rd_empty), .rd_full(rd_full),
    .pop_en(pop_en), .pop_loc(pop_loc),
    .push_en(push_en), .push_loc(push_loc), .push_card(push_card),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok)
`ifdef FREECELL_MOVE_CNT_EN
    , .move_count(move_count)
`endif
  );

  // FreeCell single-card move rules, straight from the game.
  function automatic bit model_legal(input int s, input int d);
    int sr, dr, ss, ds;
    sr = int'(b_card[s][3:0]);
    dr = int'(b_card[d][3:0]);
    ss = int'(b_card[s][5:4]);
    ds = int'(b_card[d][5:4]);
    if (s == d || s >= 12 || b_empty[s] || b_full[d]) return 1'b0;
    if (d < 8) return b_empty[d] || (dr == sr + 1 && (ss % 2) != (ds % 2));
    if (d < 12) return b_empty[d];
    if (b_empty[d]) return sr == 1;
    return ds == ss && sr == dr + 1;
  endfunction

  task automatic board_clear();
    for (int i = 0; i < 16; i++) begin
      b_card[i]  = 6'h0d;
      b_empty[i] = 1'b0;
      b_full[i]  = 1'b0;
    end
  endtask

  // Drive one request and record when each output event happens,
  // counted in falling edges after the accept edge.
  task automatic run_move(input logic [3:0] s, input logic [3:0] d,
                          output int acc, output int pop_n, output int pop_l,
                          output int push_n, output int push_l, output int push_c,
                          output int strobes, output int rsp_n, output int ok_v);
    acc = 0; pop_n = -1; pop_l = -1; push_n = -1; push_l = -1; push_c = -1;
    strobes = 0; rsp_n = -1; ok_v = -1;
    @(negedge clk);
    req_src = s; req_dst = d; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc = 1;
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (pop_en) begin strobes++; pop_n = n; pop_l = int'(pop_loc); end
      if (push_en) begin strobes++; push_n = n; push_l = int'(push_loc); push_c = int'(push_card); end
      if (rsp_valid) begin rsp_n = n; ok_v = int'(rsp_ok); break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_src = 4'd0; req_dst = 4'd0;
    board_clear();
    #12;
    checks++;
    if (req_ready !== 1'b1 || pop_en !== 1'b0 || push_en !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_ok !== 1'b0 || rd_loc !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b pop=%b push=%b rsp=%b ok=%b rd_loc=%0d, want 1 0 0 0 0 0",
               req_ready, pop_en, push_en, rsp_valid, rsp_ok, rd_loc);
    end
`ifdef FREECELL_MOVE_CNT_EN
    checks++;
    if (move_count !== 10'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", move_count);
    end
`endif
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rd_loc !== 4'd0 || pop_en !== 1'b0 || push_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ready=%b rd_loc=%0d pop=%b push=%b", req_ready, rd_loc, pop_en, push_en);
    end
  endtask

  task automatic test_directed();
    int src_t[6]  = '{0, 13, 2, 0, 4, 8};
    int dst_t[6]  = '{1, 0, 3, 9, 4, 12};
    bit ok_t[6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int acc, pn, pl, hn, hl, hc, st, rn, okv;
    int e_rn, e_pn, e_pl, e_hn, e_hl, e_hc, e_st;
    board_clear();
    b_card[0] = 6'h05;               // suit 0, rank 5
    b_card[1] = 6'h16;               // suit 1, rank 6
    b_empty[2] = 1'b1;
    b_full[9]  = 1'b1;
    b_card[8]  = 6'h21;              // ace of suit 2
    b_empty[12] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_move(src_t[k][3:0], dst_t[k][3:0], acc, pn, pl, hn, hl, hc, st, rn, okv);
      e_rn = ok_t[k] ? 6 : 4;
      e_st = ok_t[k] ? 2 : 0;
      e_pn = ok_t[k] ? 4 : -1;
      e_pl = ok_t[k] ? src_t[k] : -1;
      e_hn = ok_t[k] ? 5 : -1;
      e_hl = ok_t[k] ? dst_t[k] : -1;
      e_hc = ok_t[k] ? int'(b_card[src_t[k]]) : -1;
      if (ok_t[k] && exp_count < 1023) exp_count++;
      checks++;
      if (acc !== 1 || rn !== e_rn || okv !== int'(ok_t[k])) begin
        errors++;
        $display("FAIL directed_rsp[%0d]: got acc=%0d rsp_at=%0d ok=%0d, want 1 %0d %0d", k, acc, rn, okv, e_rn, ok_t[k]);
      end
      checks++;
      if (st !== e_st || pn !== e_pn || pl !== e_pl || hn !== e_hn || hl !== e_hl || hc !== e_hc) begin
        errors++;
        $display("FAIL directed_strobes[%0d]: got n=%0d pop@%0d/%0d push@%0d/%0d/0x%0h, want n=%0d pop@%0d/%0d push@%0d/%0d/0x%0h",
                 k, st, pn, pl, hn, hl, hc, e_st, e_pn, e_pl, e_hn, e_hl, e_hc);
      end
    end
  endtask

  task automatic test_random();
    int acc, pn, pl, hn, hl, hc, st, rn, okv;
    int s, d;
    bit lg;
    logic [1:0] su;
    logic [3:0] rk;
    for (int m = 0; m < 300; m++) begin
      for (int i = 0; i < 16; i++) begin
        su = 2'($urandom_range(3, 0));
        rk = 4'($urandom_range(13, 1));
        b_card[i]  = {su, rk};
        b_empty[i] = ($urandom_range(4, 0) == 0);
        b_full[i]  = (i >= 8 && i < 12) ? !b_empty[i] : (!b_empty[i] && $urandom_range(4, 0) == 0);
      end
      s = int'($urandom_range(15, 0));
      d = int'($urandom_range(15, 0));
      if ($urandom_range(1, 0) == 1) begin
        // Bias toward a legal move so the pop/push path is well exercised.
        s = int'($urandom_range(11, 0));
        d = (s + int'($urandom_range(15, 1))) % 16;
        b_empty[s] = 1'b0;
        b_full[d]  = 1'b0;
        su = b_card[s][5:4];
        rk = b_card[s][3:0];
        if (d < 8) begin
          b_empty[d] = (rk == 4'd13);
          b_card[d]  = {su ^ 2'b01, rk + 4'd1};
        end else if (d < 12) begin
          b_empty[d] = 1'b1;
        end else begin
          b_empty[d] = (rk == 4'd1);
          b_card[d]  = {su, rk - 4'd1};
        end
      end
      lg = model_legal(s, d);
      run_move(s[3:0], d[3:0], acc, pn, pl, hn, hl, hc, st, rn, okv);
      if (lg && exp_count < 1023) exp_count++;
      checks++;
      if (acc !== 1 || rn !== (lg ? 6 : 4) || okv !== int'(lg)) begin
        errors++;
        $display("FAIL random_rsp[%0d] %0d->%0d: got acc=%0d rsp_at=%0d ok=%0d, want legal=%0d", m, s, d, acc, rn, okv, lg);
      end
      checks++;
      if (lg ? (st !== 2 || pn !== 4 || pl !== s || hn !== 5 || hl !== d || hc !== int'(b_card[s]))
             : (st !== 0)) begin
        errors++;
        $display("FAIL random_strobes[%0d] %0d->%0d legal=%0d: got n=%0d pop@%0d/%0d push@%0d/%0d/0x%0h",
                 m, s, d, lg, st, pn, pl, hn, hl, hc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rdy_m, rsp_m, pop_m, push_m, ok_m;
    int pop_l2, push_l2;
    board_clear();
    b_card[0] = 6'h05; b_card[1] = 6'h16;
    b_card[3] = 6'h29; b_empty[8] = 1'b1;
    rdy_m = '0; rsp_m = '0; pop_m = '0; push_m = '0; ok_m = '0;
    pop_l2 = -1; push_l2 = -1;
    @(negedge clk);
    req_src = 4'd0; req_dst = 4'd1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_src = 4'd3; req_dst = 4'd8;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      rdy_m[n]  = req_ready;
      rsp_m[n]  = rsp_valid;
      ok_m[n]   = rsp_ok;
      pop_m[n]  = pop_en;
      push_m[n] = push_en;
      if (n > 7 && pop_en) pop_l2 = int'(pop_loc);
      if (n > 7 && push_en) push_l2 = int'(push_loc);
      if (n == 7) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) if (exp_count < 1023) exp_count++;
    checks++;
    if (rdy_m !== 16'h4080) begin
      errors++;
      $display("FAIL b2b_ready: got mask 0x%04h want 0x4080", rdy_m);
    end
    checks++;
    if (rsp_m !== 16'h2040 || ok_m !== 16'h2040) begin
      errors++;
      $display("FAIL b2b_rsp: got rsp 0x%04h ok 0x%04h want 0x2040 0x2040", rsp_m, ok_m);
    end
    checks++;
    if (pop_m !== 16'h0810 || push_m !== 16'h1020 || pop_l2 !== 3 || push_l2 !== 8) begin
      errors++;
      $display("FAIL b2b_strobes: got pop 0x%04h push 0x%04h locs %0d/%0d want 0x0810 0x1020 3/8",
               pop_m, push_m, pop_l2, push_l2);
    end
  endtask

  task automatic test_reset_mid_move();
    int bad;
    int acc, pn, pl, hn, hl, hc, st, rn, okv;
    board_clear();
    b_card[0] = 6'h05; b_card[1] = 6'h16;
    @(negedge clk);
    req_src = 4'd0; req_dst = 4'd1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (pop_en !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_pop: got pop_en=%b want 1", pop_en);
    end
    rst = 1'b1;
    exp_count = 0;
    #1;
    checks++;
    if (pop_en !== 1'b0 || push_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_drop: got pop=%b push=%b rsp=%b ready=%b want 0 0 0 1", pop_en, push_en, rsp_valid, req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (pop_en || push_en || rsp_valid || !req_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d bad cycles want 0", bad);
    end
    run_move(4'd0, 4'd1, acc, pn, pl, hn, hl, hc, st, rn, okv);
    exp_count = 1;
    checks++;
    if (acc !== 1 || rn !== 6 || okv !== 1 || st !== 2) begin
      errors++;
      $display("FAIL midreset_recover: got acc=%0d rsp_at=%0d ok=%0d strobes=%0d want 1 6 1 2", acc, rn, okv, st);
    end
  endtask

`ifdef FREECELL_MOVE_CNT_EN
  task automatic test_move_count();
    int acc, pn, pl, hn, hl, hc, st, rn, okv;
    checks++;
    if (move_count !== 10'(exp_count)) begin
      errors++;
      $display("FAIL count_start: got %0d want %0d", move_count, exp_count);
    end
    board_clear();
    b_card[0] = 6'h05; b_card[1] = 6'h16;
    b_card[13] = 6'h01;
    for (int i = 0; i < 1025; i++) begin
      run_move(4'd0, 4'd1, acc, pn, pl, hn, hl, hc, st, rn, okv);
      if (exp_count < 1023) exp_count++;
      if (i % 200 == 0) begin
        run_move(4'd13, 4'd1, acc, pn, pl, hn, hl, hc, st, rn, okv);
        checks++;
        if (move_count !== 10'(exp_count)) begin
          errors++;
          $display("FAIL count_progress[%0d]: got %0d want %0d", i, move_count, exp_count);
        end
      end
    end
    checks++;
    if (move_count !== 10'd1023 || exp_count != 1023) begin
      errors++;
      $display("FAIL count_saturate: got %0d want 1023", move_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_move();
`ifdef FREECELL_MOVE_CNT_EN
    test_move_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
